// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort frame controller.
// Holds the FSM state enum, counter width helper and the padding constant.
package sort_pkg;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    localparam int PAD_MAX_W = 64;
    localparam logic [PAD_MAX_W-1:0] PAD_ONES = '1;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sorter.sv
// Combinational N-input sorter network (odd-even transposition), ascending: slot 0 = minimum.
// Latency: purely combinational; the caller budgets a multicycle settle time.
// Backpressure: none, no handshake.
module sorter #(
    parameter int N  = 5,
    parameter int DW = 8
) (
    input  logic [N*DW-1:0] in_vec,
    output logic [N*DW-1:0] out_vec
);

    logic [DW-1:0] v [N];
    logic [DW-1:0] tmp;

    always_comb begin
        tmp = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = in_vec[i*DW +: DW];
        end
        // N alternating odd/even compare-exchange passes fully sort N elements.
        for (int p = 0; p < N; p++) begin
            for (int i = p % 2; i + 1 < N; i += 2) begin
                if (v[i] > v[i+1]) begin
                    tmp    = v[i];
                    v[i]   = v[i+1];
                    v[i+1] = tmp;
                end
            end
        end
        out_vec = '0;
        for (int i = 0; i < N; i++) begin
            out_vec[i*DW +: DW] = v[i];
        end
    end

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame controller: loads up to N elements, holds the sorter inputs SORT_LAT cycles, drains ascending.
// Latency: result valid SORT_LAT edges after the closing input beat is accepted.
// Backpressure: in_ready low outside LOAD; out_data/out_last held while out_valid && !out_ready.
module sort_frame_ctrl
    import sort_pkg::*;
#(
    parameter int N        = 5,
    parameter int DW       = 8,
    parameter int SORT_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int CW = cnt_w(N);
    localparam int SW = cnt_w(SORT_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [SW-1:0] SORT_LAST = SW'(SORT_LAT - 1);
    localparam logic [DW-1:0] PAD = PAD_ONES[DW-1:0];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] len_q, len_d;
    logic [SW-1:0] sort_cnt_q, sort_cnt_d;
    logic [DW-1:0] slot_q [N];
    logic [DW-1:0] slot_d [N];
    logic [DW-1:0] result_q [N];
    logic [DW-1:0] result_d [N];
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;

    logic [N*DW-1:0] slot_vec;
    logic [N*DW-1:0] sorted_vec;

    always_comb begin
        slot_vec = '0;
        for (int i = 0; i < N; i++) begin
            slot_vec[i*DW +: DW] = slot_q[i];
        end
    end

    sorter #(.N(N), .DW(DW)) u_sorter (
        .in_vec  (slot_vec),
        .out_vec (sorted_vec)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        len_d      = len_q;
        sort_cnt_d = sort_cnt_q;
        slot_d     = slot_q;
        result_d   = result_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt_q == CW'(i)) slot_d[i] = in_data;
                    end
                    if (in_last || cnt_q == CNT_LAST) begin
                        len_d      = cnt_q + CW'(1);
                        cnt_d      = '0;
                        sort_cnt_d = '0;
                        state_d    = SORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                if (sort_cnt_q == SORT_LAST) begin
                    for (int i = 0; i < N; i++) begin
                        result_d[i] = sorted_vec[i*DW +: DW];
                    end
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    sort_cnt_d = sort_cnt_q + SW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (k_q == len_q - CW'(1)) begin
                        // Re-pad so a later short frame never sees stale data.
                        for (int i = 0; i < N; i++) begin
                            slot_d[i] = PAD;
                        end
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != LOAD);
        out_last_d  = (state_d == DRAIN) && (k_d == len_d - CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            k_q         <= '0;
            len_q       <= '0;
            sort_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot_q[i]   <= PAD;
                result_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            len_q       <= len_d;
            sort_cnt_q  <= sort_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            slot_q      <= slot_d;
            result_q    <= result_d;
        end
    end

    // Held low during reset so a producer never sees a ready it cannot use.
    assign in_ready  = (state_q == LOAD) && !rst;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == CW'(i)) out_data = result_q[i];
        end
    end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl: directed and random frames against a selection-sort reference.
// Two instances (SORT_LAT=1 and 3) share stimulus, gated by sel.
module tb_sort_frame_ctrl;

    localparam int N  = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready1, out_valid1, out_last1, busy1;
    logic [DW-1:0] out_data1;
    logic          in_ready3, out_valid3, out_last3, busy3;
    logic [DW-1:0] out_data3;

    logic          o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [DW-1:0] o_out_data;

    int vectors = 0;
    int miscompares = 0;
    int stim [N];

    always #5 clk = ~clk;

    sort_frame_ctrl #(.N(N), .DW(DW), .SORT_LAT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid1),
        .out_ready (out_ready & ~sel),
        .out_data  (out_data1),
        .out_last  (out_last1),
        .busy      (busy1)
    );

    sort_frame_ctrl #(.N(N), .DW(DW), .SORT_LAT(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid3),
        .out_ready (out_ready & sel),
        .out_data  (out_data3),
        .out_last  (out_last3),
        .busy      (busy3)
    );

    assign o_in_ready  = sel ? in_ready3  : in_ready1;
    assign o_out_valid = sel ? out_valid3 : out_valid1;
    assign o_out_last  = sel ? out_last3  : out_last1;
    assign o_busy      = sel ? busy3      : busy1;
    assign o_out_data  = sel ? out_data3  : out_data1;

    // Drives stim[0..n-1] as one frame and checks latency, drain order and flags.
    // stall: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 stops draining early.
    task automatic run_frame(input string tag, input int n, input bit use_last, input int stall,
                             input int lat, input bit noise, input int abort_at);
        int  e [N];
        bit  used [N];
        int  best;
        int  cyc;
        int  idx;
        bit  rdy;
        for (int i = 0; i < N; i++) begin
            used[i] = 1'b0;
            e[i]    = 0;
        end
        for (int j = 0; j < n; j++) begin
            best = -1;
            for (int i = 0; i < n; i++) begin
                if (!used[i] && (best < 0 || stim[i] < stim[best])) best = i;
            end
            used[best] = 1'b1;
            e[j] = stim[best];
        end

        cyc = 0;
        while (o_in_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(stim[i]);
            in_last  = use_last && (i == n - 1);
            vectors++;
            if (o_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s load_beat%0d: in_ready=%b expected 1", tag, i, o_in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = noise;
        in_data  = 8'($urandom);
        in_last  = 1'b0;

        vectors++;
        if (o_busy !== 1'b1 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s enter_sort: busy=%b out_valid=%b in_ready=%b expected 1 0 0",
                     tag, o_busy, o_out_valid, o_in_ready);
        end

        cyc = 0;
        while (o_out_valid !== 1'b1 && cyc < 50) begin
            if (noise) begin
                vectors++;
                if (o_in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s sort_in_ready: in_ready=%b expected 0", tag, o_in_ready);
                end
                in_data = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != lat) begin
            miscompares++;
            $display("FAIL %s latency: out_valid after %0d edges expected %0d", tag, cyc, lat);
        end

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            if (abort_at >= 0 && idx == abort_at) break;
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            vectors++;
            if (o_out_valid !== 1'b1 || o_out_data !== 8'(e[idx]) || o_out_last !== (idx == n - 1)) begin
                miscompares++;
                $display("FAIL %s drain%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         tag, idx, o_out_valid, o_out_data, o_out_last, e[idx], (idx == n - 1));
            end
            if (noise) begin
                vectors++;
                if (o_in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s drain_in_ready: in_ready=%b expected 0", tag, o_in_ready);
                end
                in_data = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (abort_at < 0) begin
            vectors++;
            if (idx != n) begin
                miscompares++;
                $display("FAIL %s drain_count: emitted %0d expected %0d", tag, idx, n);
            end
            vectors++;
            if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s frame_end: out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                         tag, o_out_valid, o_busy, o_in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || out_last1 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b out_last=%b busy=%b expected 0 0 0 0",
                     in_ready1, out_valid1, out_last1, busy1);
        end
        vectors++;
        if (out_data1 !== 8'd0 || out_data3 !== 8'd0 || out_valid3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: out_data1=%0d out_data3=%0d out_valid3=%b expected 0 0 0",
                     out_data1, out_data3, out_valid3);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: in_ready1=%b in_ready3=%b expected 1 1", in_ready1, in_ready3);
        end
    endtask

    task automatic test_basic();
        stim = '{30, 10, 50, 20, 40};
        run_frame("basic", 5, 1'b0, 0, 1, 1'b0, -1);
    endtask

    task automatic test_short_frame();
        stim = '{7, 3, 0, 0, 0};
        run_frame("short", 2, 1'b1, 0, 1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        stim = '{255, 0, 255, 0, 128};
        run_frame("dup_pad", 5, 1'b0, 0, 1, 1'b0, -1);
        stim = '{4, 4, 4, 4, 4};
        run_frame("last_on_nth", 5, 1'b1, 0, 1, 1'b0, -1);
        stim = '{200, 0, 0, 0, 0};
        run_frame("single", 1, 1'b1, 0, 1, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        stim = '{60, 15, 90, 15, 45};
        run_frame("stall", 5, 1'b0, 1, 1, 1'b1, -1);
    endtask

    task automatic test_reset_mid_drain();
        stim = '{12, 34, 56, 78, 90};
        run_frame("abort", 5, 1'b0, 0, 1, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || out_last1 !== 1'b0 || out_data1 !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_reset: out_valid=%b busy=%b out_last=%b data=%0d expected 0 0 0 0",
                     out_valid1, busy1, out_last1, out_data1);
        end
        rst = 1'b0;
        stim = '{9, 8, 7, 6, 5};
        run_frame("after_reset", 5, 1'b0, 0, 1, 1'b0, -1);
    endtask

    task automatic test_sort_lat3();
        sel = 1'b1;
        stim = '{30, 10, 50, 20, 40};
        run_frame("lat3", 5, 1'b0, 0, 3, 1'b0, -1);
        stim = '{5, 250, 0, 0, 0};
        run_frame("lat3_short", 2, 1'b1, 1, 3, 1'b1, -1);
        sel = 1'b0;
    endtask

    task automatic test_random();
        int  n;
        bit  ul;
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(1, N);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) stim[i] = ($urandom_range(0, 1) == 1) ? 255 : 0;
                else stim[i] = $urandom_range(0, 255);
            end
            ul = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            run_frame("random", n, ul, $urandom_range(0, 2), sel ? 3 : 1, 1'($urandom_range(0, 1)), -1);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_drain();
        test_sort_lat3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
